// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-read-port register file.
//   DEF_DATA_W / DEF_ADDR_W : default register width and address width
//   NUM_BYTES / DEPTH       : byte lanes per register and entry count at the defaults
//   mergeByte()             : one byte lane of an old/new merge under a lane enable
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NUM_BYTES  = DEF_DATA_W / 8;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;

  // Used by both the storage write path and the read-port bypass, so the
  // forwarded value is by construction identical to what lands in storage.
  function automatic logic [7:0] mergeByte(input logic [7:0] oldByte,
                                           input logic [7:0] newByte,
                                           input logic       laneEn);
    return laneEn ? newByte : oldByte;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One synchronous read port of regfile_mp.
//   clk, rst_n : clock, asynchronous active-low reset
//   rdEn       : read enable; rdAddr : read address
//   memData    : current (pre-write) storage contents at rdAddr
//   wrEn, wrAddr, wrData, wrBe : write request seen this cycle (for bypass)
//   rdData     : registered read data; rdValid : rdData updated on last edge
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdEn,
  input  logic [ADDR_W-1:0]   rdAddr,
  input  logic [DATA_W-1:0]   memData,
  input  logic                wrEn,
  input  logic [ADDR_W-1:0]   wrAddr,
  input  logic [DATA_W-1:0]   wrData,
  input  logic [DATA_W/8-1:0] wrBe,
  output logic [DATA_W-1:0]   rdData,
  output logic                rdValid
);

  localparam int nBytes = DATA_W / 8;

  logic [DATA_W-1:0] nextData;
  logic              hitWrite;

  assign hitWrite = BYPASS && wrEn && (rdAddr == wrAddr);

  always_comb begin
    nextData = memData;
    if (ZERO_REG && (rdAddr == '0)) begin
      // Forced here so neither stale storage nor a bypassed write can leak out.
      nextData = '0;
    end else if (hitWrite) begin
      for (int k = 0; k < nBytes; k++) begin
        nextData[8*k +: 8] = mergeByte(memData[8*k +: 8], wrData[8*k +: 8], wrBe[k]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdData  <= '0;
      rdValid <= 1'b0;
    end else begin
      rdValid <= rdEn;
      if (rdEn) begin
        rdData <= nextData;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with byte-lane writes,
// optional hardwired zero register and optional write-to-read bypass.
//   clk, rst_n : clock, asynchronous active-low clear of storage and outputs
//   rd_en      : [NUM_RD] per-port read enables
//   rd_addr    : [NUM_RD*ADDR_W] read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data    : [NUM_RD*DATA_W] registered read data, port i at [i*DATA_W +: DATA_W]
//   rd_valid   : [NUM_RD] port data updated on the last edge
//   wr_en, wr_addr, wr_data, wr_be : write strobe, address, data, byte-lane enables
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  output logic [NUM_RD-1:0]        rd_valid
);

  localparam int nBytes = DATA_W / 8;
  localparam int depth  = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [depth];
  logic              wrAllowed;

  // Writes to register 0 are dropped at the source when it is hardwired.
  assign wrAllowed = wr_en && !(ZERO_REG && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < depth; e++) begin
        mem[e] <= '0;
      end
    end else if (wrAllowed) begin
      for (int k = 0; k < nBytes; k++) begin
        mem[wr_addr][8*k +: 8] <= mergeByte(mem[wr_addr][8*k +: 8], wr_data[8*k +: 8], wr_be[k]);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : gRdPort
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) uRdPort (
      .clk    (clk),
      .rst_n  (rst_n),
      .rdEn   (rd_en[gi]),
      .rdAddr (rd_addr[gi*ADDR_W +: ADDR_W]),
      .memData(mem[rd_addr[gi*ADDR_W +: ADDR_W]]),
      .wrEn   (wr_en),
      .wrAddr (wr_addr),
      .wrData (wr_data),
      .wrBe   (wr_be),
      .rdData (rd_data[gi*DATA_W +: DATA_W]),
      .rdValid(rd_valid[gi])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (zero register + bypass) and a
// plain instance (no zero register, no bypass) share one stimulus stream and
// are both checked every cycle against an array model of the register file.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  rdEn;
  logic [9:0]  rdAddr;
  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [3:0]  wrBe;
  logic [63:0] rdDataA, rdDataB;
  logic [1:0]  rdValidA, rdValidB;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dutA (
    .clk(clk), .rst_n(rst_n), .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdDataA),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .wr_be(wrBe), .rd_valid(rdValidA)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) dutB (
    .clk(clk), .rst_n(rst_n), .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdDataB),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .wr_be(wrBe), .rd_valid(rdValidB)
  );

  // Model state: register contents and expected outputs for each instance.
  logic [31:0] mA [32];
  logic [31:0] mB [32];
  logic [31:0] eDA [2];
  logic [31:0] eDB [2];
  logic [1:0]  eVA, eVB;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) begin
      mA[i] = '0;
      mB[i] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      eDA[i] = '0;
      eDB[i] = '0;
    end
    eVA = '0;
    eVB = '0;
  endtask

  // A read sees the register as it is after this edge when bypass is on,
  // as it was before the edge when bypass is off.
  task automatic stepModel();
    logic [31:0] nA [32];
    logic [31:0] nB [32];
    logic [4:0]  a;
    nA = mA;
    nB = mB;
    if (wrEn) begin
      for (int k = 0; k < 4; k++) begin
        if (wrBe[k]) begin
          if (wrAddr != 5'd0) nA[wrAddr][8*k +: 8] = wrData[8*k +: 8];
          nB[wrAddr][8*k +: 8] = wrData[8*k +: 8];
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      a = rdAddr[i*5 +: 5];
      if (rdEn[i]) begin
        eDA[i] = (a == 5'd0) ? 32'd0 : nA[a];
        eDB[i] = mB[a];
      end
      eVA[i] = rdEn[i];
      eVB[i] = rdEn[i];
    end
    mA = nA;
    mB = nB;
  endtask

  task automatic compareAll();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("A.data%0d", i), {32'd0, rdDataA[i*32 +: 32]}, {32'd0, eDA[i]});
      check($sformatf("B.data%0d", i), {32'd0, rdDataB[i*32 +: 32]}, {32'd0, eDB[i]});
      check($sformatf("A.valid%0d", i), {63'd0, rdValidA[i]}, {63'd0, eVA[i]});
      check($sformatf("B.valid%0d", i), {63'd0, rdValidB[i]}, {63'd0, eVB[i]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) stepModel();
    #1;
    compareAll();
  endtask

  task automatic idle();
    rdEn = '0; rdAddr = '0; wrEn = 1'b0; wrAddr = '0; wrData = '0; wrBe = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wrEn = 1'b1; wrAddr = a; wrData = d; wrBe = be;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    rdEn[p] = 1'b1;
    rdAddr[p*5 +: 5] = a;
  endtask

  // Called just after an edge; reset is pulsed entirely between edges.
  task automatic asyncResetPulse();
    #2;
    rst_n = 1'b0;
    clearModel();
    #1;
    compareAll();
    check("async.dataA", rdDataA, 64'd0);
    check("async.validB", {62'd0, rdValidB}, 64'd0);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [4:0] pickAddr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 5'd0;
    if (r == 1) return 5'd31;
    if (r < 7) return 5'(r);
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    idle();
    clearModel();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compareAll();
    rst_n = 1'b1;

    // Reset clears outputs and storage without a clock edge.
    wr(5'd7, 32'hCAFEF00D, 4'hF); tick(); idle();
    rd(0, 5'd7); tick(); idle();
    check("t1.pre", {32'd0, rdDataA[31:0]}, 64'h0000_0000_CAFE_F00D);
    asyncResetPulse();
    rd(0, 5'd7); tick(); idle();
    check("t1.reg7", {32'd0, rdDataA[31:0]}, 64'd0);

    // Basic write/read on both ports, plus the highest address.
    wr(5'd5, 32'hDEADBEEF, 4'hF); tick(); idle();
    rd(0, 5'd5); rd(1, 5'd5); tick(); idle();
    check("t2.both", rdDataA, 64'hDEADBEEF_DEADBEEF);
    check("t2.valid", {62'd0, rdValidA}, 64'd3);
    wr(5'd31, 32'h31313131, 4'hF); tick(); idle();
    rd(1, 5'd31); tick(); idle();
    check("t2.reg31", {32'd0, rdDataA[63:32]}, 64'h31313131);

    // Byte-lane write.
    wr(5'd9, 32'h11223344, 4'hF); tick(); idle();
    wr(5'd9, 32'hAABBCCDD, 4'b0101); tick(); idle();
    rd(0, 5'd9); tick(); idle();
    check("t3.A", {32'd0, rdDataA[31:0]}, 64'h11BB33DD);
    check("t3.B", {32'd0, rdDataB[31:0]}, 64'h11BB33DD);

    // Same-cycle write and read: forwarded on A, pre-write on B.
    wr(5'd3, 32'd0, 4'hF); tick(); idle();
    wr(5'd3, 32'h10, 4'hF); rd(0, 5'd3); tick(); idle();
    check("t4.bypass", {32'd0, rdDataA[31:0]}, 64'h10);
    check("t4.nobypass", {32'd0, rdDataB[31:0]}, 64'h0);
    rd(0, 5'd3); tick(); idle();
    check("t4.after", {32'd0, rdDataB[31:0]}, 64'h10);

    // Register 0.
    wr(5'd0, 32'hFFFFFFFF, 4'hF); rd(0, 5'd0); tick(); idle();
    check("t5.A.same", {32'd0, rdDataA[31:0]}, 64'h0);
    check("t5.B.same", {32'd0, rdDataB[31:0]}, 64'h0);
    rd(0, 5'd0); tick(); idle();
    check("t5.A.later", {32'd0, rdDataA[31:0]}, 64'h0);
    check("t5.B.later", {32'd0, rdDataB[31:0]}, 64'hFFFFFFFF);

    // Hold while disabled, then reset coincident with a write.
    wr(5'd4, 32'h1234, 4'hF); tick(); idle();
    rd(1, 5'd4); tick(); idle();
    check("t6.read", {32'd0, rdDataA[63:32]}, 64'h1234);
    for (int j = 0; j < 3; j++) begin
      wr(5'(10 + j), $urandom, 4'hF); tick(); idle();
      check("t6.hold", {32'd0, rdDataA[63:32]}, 64'h1234);
      check("t6.valid1", {63'd0, rdValidA[1]}, 64'd0);
    end
    wr(5'd2, 32'h55, 4'hF);
    #2;
    rst_n = 1'b0;
    clearModel();
    tick();
    idle();
    rst_n = 1'b1;
    rd(0, 5'd2); tick(); idle();
    check("t6.reg2", {32'd0, rdDataA[31:0]}, 64'h0);
    check("t6.reg2B", {32'd0, rdDataB[31:0]}, 64'h0);

    // Randomized traffic with occasional asynchronous clears.
    for (int n = 0; n < 600; n++) begin
      rdEn   = 2'($urandom_range(0, 3));
      rdAddr = {pickAddr(), pickAddr()};
      if ($urandom_range(0, 3) == 0) rdAddr[9:5] = rdAddr[4:0];
      wrEn   = ($urandom_range(0, 2) != 0);
      wrAddr = ($urandom_range(0, 2) == 0) ? rdAddr[4:0] : pickAddr();
      wrData = $urandom;
      wrBe   = 4'($urandom_range(0, 15));
      tick();
      if ($urandom_range(0, 99) == 0) asyncResetPulse();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
